mult_slot_arbiter: RTL and testbench
====================================

Name: mult_slot_arbiter

Overview:
- Controller for the shared iterative multiply unit.
- Arbitrates mult/multu issue requests from the two execute slots and sequences a radix-2 shift-add datapath.
- Produces the busy indication consumed by the hazard detector as busy_multE.
- Owns the HI/LO result registers.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH bits.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start0_i  input  1  execute slot 0 (older instruction) requests a multiply.
start1_i  input  1  execute slot 1 (younger instruction) requests a multiply.
signed0_i  input  1  slot 0 operation is signed (mult) when 1, unsigned (multu) when 0.
signed1_i  input  1  slot 1 signedness.
a0_i, b0_i  input  WIDTH  slot 0 operands.
a1_i, b1_i  input  WIDTH  slot 1 operands.
grant_o  output  2  one-hot acceptance of the request in the current cycle; combinational.
busy_o  output  1  unit occupied; drives busy_multE.
owner_o  output  1  slot index of the operation in flight; held after completion.
done_o  output  1  one-cycle pulse; hi_o/lo_o are updated and valid in that cycle.
hi_o  output  WIDTH  HI register, upper half of the product.
lo_o  output  WIDTH  LO register, lower half of the product.

Behaviour:
- Reset: state=IDLE, busy_o=0, done_o=0, owner_o=0, hi_o=0, lo_o=0, internal accumulator and counter cleared.
- Reset takes priority over every other event, including mid-operation; an in-flight product is discarded.
- States: IDLE, CALC, FIX, DONE. busy_o = (state != IDLE), a registered decode.
- Arbitration happens in IDLE only; fixed priority.
  - start0_i -> grant_o=2'b01, else start1_i -> grant_o=2'b10, else 2'b00.
  - grant_o=0 in all other states; a start outside IDLE is ignored with no side effects.
  - A losing slot must rely on the hazard detector stalling it; no request is queued.
- Accept (cycle t):
  - Latch owner_o and the sign flag.
  - Magnitudes: |a| and |b| if signed, else raw a and b.
  - neg = signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Multiplicand register (2*WIDTH) = zero-extended |a|; multiplier register = |b|; accumulator = 0; counter = 0.
  - Next state CALC.
- CALC, one iteration per cycle:
  - If mplr[0], acc += mcand (mod 2^(2*WIDTH)).
  - mcand <<= 1; mplr >>= 1; counter++.
  - After the WIDTH-th iteration -> FIX. Cycles t+1 .. t+WIDTH.
- FIX (cycle t+WIDTH+1):
  - Product = neg ? (~acc + 1) : acc.
  - hi_o/lo_o load the product at the end of this cycle -> DONE.
- DONE (cycle t+WIDTH+2): done_o=1, busy_o=1, grant_o=0 -> IDLE.
- Earliest next accept is t+WIDTH+3.
- Latency: WIDTH+2 cycles from accept to done_o; start and busy together cover every cycle from t through DONE.
- hi_o, lo_o and owner_o hold their values until the next FIX; no other writes to HI/LO.
- Signed edge case: most-negative operand; magnitude 2^(WIDTH-1) is representable in the WIDTH-bit unsigned register and gives the correct result.
- All arithmetic is unsigned on the 2*WIDTH-bit path; no overflow flag.

Optional Feature:
MULT_EARLY_OUT_EN
- Defined: in CALC, after each iteration's update, if the shifted multiplier register is 0, go to FIX immediately. At least one CALC cycle is always executed.
  - Latency = k+2, where k = max(1, bit length of |b|).
  - done_o and busy_o timing follow the actual latency.
- Undefined: exactly WIDTH CALC cycles regardless of operands.
- Results are identical with and without the macro.

Test Plan:
1. Reset, then start0 multu a=6, b=7 -> grant=01; busy high 34 cycles; done pulse at accept+34; hi=0x00000000, lo=0x0000002A; owner=0. With MULT_EARLY_OUT_EN: done at accept+5.
2. start1 only, mult a=-3 (0xFFFFFFFD), b=5 -> grant=10; owner=1; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
3. start0 and start1 in the same IDLE cycle (slot0 multu 2*3, slot1 multu 4*5) -> grant=01 only; result lo=6; slot1 request dropped; hi/lo unchanged by slot1.
4. start0 multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
5. start1 asserted during CALC -> grant=00, no state change, in-flight result unaffected. Also check hi/lo hold after done until the next FIX.
6. reset asserted at accept+10 -> next cycle busy=0, hi=lo=0, no done pulse. A start in the following cycle is accepted normally.

Source files
------------

// File: rtl/mult_slot_arbiter_if.sv
// Issue/result bundle between the two execute slots and the shared
// iterative multiply unit. The master side is the execute stage plus the
// consumers of HI/LO and busy; the slave side is mult_slot_arbiter.
interface mult_slot_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             start0_i;
    logic             start1_i;
    logic             signed0_i;
    logic             signed1_i;
    logic [WIDTH-1:0] a0_i;
    logic [WIDTH-1:0] b0_i;
    logic [WIDTH-1:0] a1_i;
    logic [WIDTH-1:0] b1_i;
    logic [1:0]       grant_o;
    logic             busy_o;
    logic             owner_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start0_i, start1_i, signed0_i, signed1_i,
        output a0_i, b0_i, a1_i, b1_i,
        input  grant_o, busy_o, owner_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start0_i, start1_i, signed0_i, signed1_i,
        input  a0_i, b0_i, a1_i, b1_i,
        output grant_o, busy_o, owner_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_slot_arbiter.sv
// Shared iterative multiplier controller: fixed-priority arbitration of the
// two execute slots, radix-2 shift-add sequencing on magnitudes, sign fix-up
// of the 2*WIDTH product and ownership of the HI/LO registers.
// Optional build macro MULT_EARLY_OUT_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (at least one CALC cycle).
// CNT_W must satisfy 2**CNT_W > WIDTH.
module mult_slot_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    mult_slot_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

    // Magnitude of an operand; the most-negative value maps to 2**(WIDTH-1),
    // which still fits the unsigned WIDTH-bit register.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Restore the product sign after the unsigned magnitude multiply.
    function automatic logic [2*WIDTH-1:0] f_apply_sign(input logic [2*WIDTH-1:0] acc,
                                                        input logic neg);
        return neg ? (~acc + 1'b1) : acc;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_owner;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplr;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [1:0]           w_grant;
    logic                 w_accept;
    logic                 w_sel_sign;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]     w_mplr_shift;
    logic                 w_calc_last;
    logic [2*WIDTH-1:0]   w_product;

    // Operand selection follows the grant; only meaningful while accepting.
    assign w_accept   = |w_grant;
    assign w_sel_sign = w_grant[1] ? bus.signed1_i : bus.signed0_i;
    assign w_sel_a    = w_grant[1] ? bus.a1_i      : bus.a0_i;
    assign w_sel_b    = w_grant[1] ? bus.b1_i      : bus.b0_i;
    assign w_mag_a    = f_mag(w_sel_a, w_sel_sign);
    assign w_mag_b    = f_mag(w_sel_b, w_sel_sign);

    // One shift-add iteration; the accumulator wraps modulo 2**(2*WIDTH).
    assign w_acc_nxt    = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplr_shift = r_mplr >> 1;
    assign w_product    = f_apply_sign(r_acc, r_neg);

`ifdef MULT_EARLY_OUT_EN
    // Once no multiplier bits remain, further iterations add nothing.
    assign w_calc_last = (r_cnt == LP_LAST) || (w_mplr_shift == '0);
`else
    assign w_calc_last = (r_cnt == LP_LAST);
`endif

    // State register with registered decodes of busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state logic: accept -> WIDTH (or fewer) iterations -> fix -> done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nxt = S_CALC;
            S_CALC:  if (w_calc_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: fixed-priority grant, only while idle; losers are not queued.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == S_IDLE) begin
            if (bus.start0_i)      w_grant = 2'b01;
            else if (bus.start1_i) w_grant = 2'b10;
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, load HI/LO in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_neg   <= 1'b0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept) begin
            r_owner <= w_grant[1];
            r_neg   <= w_sel_sign & (w_sel_a[WIDTH-1] ^ w_sel_b[WIDTH-1]);
            r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplr  <= w_mag_b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CALC) begin
            r_acc   <= w_acc_nxt;
            r_mcand <= r_mcand << 1;
            r_mplr  <= w_mplr_shift;
            r_cnt   <= r_cnt + CNT_W'(1);
        end else if (r_state == S_FIX) begin
            r_hi    <= w_product[2*WIDTH-1:WIDTH];
            r_lo    <= w_product[WIDTH-1:0];
        end
    end

    assign bus.grant_o = w_grant;
    assign bus.busy_o  = r_busy;
    assign bus.owner_o = r_owner;
    assign bus.done_o  = r_done;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

endmodule

// File: tb/tb_mult_slot_arbiter.sv
// Directed bench for mult_slot_arbiter with hand-computed products.
module tb_mult_slot_arbiter;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mult_slot_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mult_slot_arbiter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected accept-to-done latency for multiplier operand b.
    function automatic int f_lat(input logic [WIDTH-1:0] b, input logic sg);
        logic [WIDTH-1:0] m;
        int k;
        m = (sg && b[WIDTH-1]) ? (~b + 1'b1) : b;
        k = 0;
        for (int i = 0; i < WIDTH; i++) if (m[i]) k = i + 1;
        if (k == 0) k = 1;
`ifdef MULT_EARLY_OUT_EN
        return k + 2;
`else
        return WIDTH + 2;
`endif
    endfunction

    // Called at a negedge: present a request, check grant, pass the accept edge.
    task automatic issue(input logic s0, input logic s1, input logic sg0, input logic sg1,
                         input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                         input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                         input logic [1:0] exp_grant, input string tag);
        bus.start0_i  = s0;
        bus.start1_i  = s1;
        bus.signed0_i = sg0;
        bus.signed1_i = sg1;
        bus.a0_i = a0;
        bus.b0_i = b0;
        bus.a1_i = a1;
        bus.b1_i = b1;
        #1;
        chk({tag, "_grant"}, {62'd0, bus.grant_o}, {62'd0, exp_grant});
        @(posedge clk);
        #1;
        bus.start0_i = 1'b0;
        bus.start1_i = 1'b0;
    endtask

    // Wait (bounded) for done, then check latency, busy coverage, result and hold.
    task automatic wait_done(input int elapsed, input int exp_lat,
                             input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo,
                             input logic exp_owner, input string tag);
        int n;
        logic busy_ok;
        n = elapsed;
        busy_ok = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
            if (bus.done_o === 1'b1) break;
        end
        chk({tag, "_lat"},   n, exp_lat);
        chk({tag, "_busy"},  {63'd0, busy_ok}, 64'd1);
        chk({tag, "_hi"},    {32'd0, bus.hi_o}, {32'd0, exp_hi});
        chk({tag, "_lo"},    {32'd0, bus.lo_o}, {32'd0, exp_lo});
        chk({tag, "_owner"}, {63'd0, bus.owner_o}, {63'd0, exp_owner});
        @(negedge clk);
        chk({tag, "_done_clr"}, {63'd0, bus.done_o}, 64'd0);
        chk({tag, "_idle"},     {63'd0, bus.busy_o}, 64'd0);
        chk({tag, "_hi_hold"},  {32'd0, bus.hi_o}, {32'd0, exp_hi});
        chk({tag, "_lo_hold"},  {32'd0, bus.lo_o}, {32'd0, exp_lo});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.start0_i = 1'b0;
        bus.start1_i = 1'b0;
        bus.signed0_i = 1'b0;
        bus.signed1_i = 1'b0;
        bus.a0_i = '0;
        bus.b0_i = '0;
        bus.a1_i = '0;
        bus.b1_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {63'd0, bus.busy_o},  64'd0);
        chk("rst_done",  {63'd0, bus.done_o},  64'd0);
        chk("rst_owner", {63'd0, bus.owner_o}, 64'd0);
        chk("rst_hi",    {32'd0, bus.hi_o},    64'd0);
        chk("rst_lo",    {32'd0, bus.lo_o},    64'd0);
        chk("rst_grant", {62'd0, bus.grant_o}, 64'd0);

        // 1: slot0 multu 6*7
        issue(1, 0, 0, 0, 32'd6, 32'd7, 32'd0, 32'd0, 2'b01, "t1");
        wait_done(0, f_lat(32'd7, 1'b0), 32'h0000_0000, 32'h0000_002A, 1'b0, "t1");

        // 2: slot1 mult -3*5
        issue(0, 1, 0, 1, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd5, 2'b10, "t2");
        wait_done(0, f_lat(32'd5, 1'b1), 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, "t2");

        // 3: both slots request; slot0 wins, slot1 dropped
        issue(1, 1, 0, 0, 32'd2, 32'd3, 32'd4, 32'd5, 2'b01, "t3");
        wait_done(0, f_lat(32'd3, 1'b0), 32'h0000_0000, 32'h0000_0006, 1'b0, "t3");

        // 4: unsigned all-ones squared, then signed most-negative squared
        issue(1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2'b01, "t4a");
        wait_done(0, f_lat(32'hFFFF_FFFF, 1'b0), 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "t4a");
        issue(1, 0, 1, 0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 2'b01, "t4b");
        wait_done(0, f_lat(32'h8000_0000, 1'b1), 32'h4000_0000, 32'h0000_0000, 1'b0, "t4b");

        // 5: slot1 request during CALC is ignored; result 9*13
        issue(1, 0, 0, 0, 32'd9, 32'd13, 32'd0, 32'd0, 2'b01, "t5");
        @(negedge clk);
        @(negedge clk);
        bus.start1_i = 1'b1;
        bus.signed1_i = 1'b0;
        bus.a1_i = 32'd100;
        bus.b1_i = 32'd100;
        #1;
        chk("t5_grant_busy", {62'd0, bus.grant_o}, 64'd0);
        @(negedge clk);
        bus.start1_i = 1'b0;
        wait_done(3, f_lat(32'd13, 1'b0), 32'h0000_0000, 32'd117, 1'b0, "t5");

        // 6: reset at accept+10 discards the product; then a normal accept
        issue(1, 0, 0, 0, 32'd3, 32'h0001_2345, 32'd0, 32'd0, 2'b01, "t6");
        repeat (9) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_busy_pre", {63'd0, bus.busy_o}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy_rst", {63'd0, bus.busy_o}, 64'd0);
        chk("t6_done_rst", {63'd0, bus.done_o}, 64'd0);
        chk("t6_hi_rst",   {32'd0, bus.hi_o},   64'd0);
        chk("t6_lo_rst",   {32'd0, bus.lo_o},   64'd0);
        issue(1, 0, 0, 0, 32'd6, 32'd7, 32'd0, 32'd0, 2'b01, "t6b");
        wait_done(0, f_lat(32'd7, 1'b0), 32'h0000_0000, 32'h0000_002A, 1'b0, "t6b");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
